// File: rtl/sseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// sseg_scan_ctrl
//
// Time-multiplexing scan controller for a multi-digit common-anode seven-segment
// display. One external hex-to-seven-segment decoder is shared by all digits:
// this block presents one nibble on hex_out, and the decoder's active-low
// pattern comes back on sseg_in, where it is registered onto seg_out.
//
// New display values arrive through a valid/ready handshake. They wait in a
// pending register and are copied into the shadow register only at a frame
// boundary, so a frame never shows a mix of old and new digits.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   en          scan enable; low blanks the display and parks the scanner
//   load_valid  producer offers load_data
//   load_data   packed hex value, nibble i is digit i (digit 0 = LS nibble)
//   load_ready  block can accept a value (pending register empty)
//   hex_out     nibble presented to the shared decoder
//   sseg_in     active-low segments from the decoder (combinational of hex_out)
//   seg_out     registered active-low segments to the pins
//   an_out      registered active-low anode enables, bit i is digit i
//
// Parameters:
//   DIGITS        number of digits scanned (1..8)
//   PRESCALE      clk cycles each digit is driven (>= 2)
//   BLANK_CYCLES  clk cycles with all anodes off between digits (>= 1)
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, a digit i > 0 whose nibble and all more-significant nibbles
//   are zero shows a blank pattern (its anode still asserts). Digit 0 always
//   displays. When undefined, every digit shows its nibble.
// -----------------------------------------------------------------------------
module sseg_scan_ctrl #(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load_valid,
    input  logic [4*DIGITS-1:0]   load_data,
    output logic                  load_ready,
    output logic [3:0]            hex_out,
    input  logic [6:0]            sseg_in,
    output logic [6:0]            seg_out,
    output logic [DIGITS-1:0]     an_out
);

    localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] PRE_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [6:0]    SEG_OFF  = 7'h7F;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t                state;
    logic [IW-1:0]         idx;
    logic [CW-1:0]         cnt;
    logic [4*DIGITS-1:0]   shadow;
    logic [4*DIGITS-1:0]   pend;
    logic                  pend_flag;
    logic [6:0]            drive_seg;

    // Handshake: a transfer happens on a rising clk edge where load_valid and
    // load_ready are both high; load_ready is high exactly when the pending
    // register is empty. A producer seeing load_ready low must hold its offer.
    assign load_ready = !pend_flag;

    // The decoder sees the nibble of the digit currently selected; during
    // BLANK it already shows the next digit so the decoder has time to settle.
    assign hex_out = shadow[{idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    // upper_zero[i]: nibble i and every more-significant nibble are zero.
    logic [DIGITS-1:0] upper_zero;

    always_comb begin
        upper_zero = '0;
        for (int i = 0; i < DIGITS; i++) begin
            upper_zero[i] = ((shadow >> (4 * i)) == '0);
        end
    end

    assign drive_seg = ((idx != '0) && upper_zero[idx]) ? SEG_OFF : sseg_in;
`else
    assign drive_seg = sseg_in;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_OFF;
            idx       <= '0;
            cnt       <= '0;
            shadow    <= '0;
            pend      <= '0;
            pend_flag <= 1'b0;
            seg_out   <= SEG_OFF;
            an_out    <= '1;
        end else begin
            // Capture and commit never coincide: capture needs an empty
            // pending register, commit needs a full one.
            if (load_valid && !pend_flag) begin
                pend      <= load_data;
                pend_flag <= 1'b1;
            end

            // While parked there is no frame to tear, so commit right away.
            if (state == ST_OFF && pend_flag) begin
                shadow    <= pend;
                pend_flag <= 1'b0;
            end

            if (!en) begin
                state   <= ST_OFF;
                idx     <= '0;
                cnt     <= '0;
                seg_out <= SEG_OFF;
                an_out  <= '1;
            end else begin
                case (state)
                    ST_OFF: begin
                        state   <= ST_BLANK;
                        idx     <= '0;
                        cnt     <= '0;
                        seg_out <= SEG_OFF;
                        an_out  <= '1;
                    end

                    ST_BLANK: begin
                        seg_out <= SEG_OFF;
                        an_out  <= '1;
                        if (cnt == BLK_LAST) begin
                            state <= ST_DRIVE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end

                    ST_DRIVE: begin
                        // Outputs follow the state one cycle later, so the
                        // last drive cycle is still registered on the edge
                        // that leaves DRIVE.
                        an_out  <= ~(DIGITS'(1) << idx);
                        seg_out <= drive_seg;
                        if (cnt == PRE_LAST) begin
                            state <= ST_BLANK;
                            cnt   <= '0;
                            if (idx == IDX_LAST) begin
                                idx <= '0;
                                // End of frame: the only tear-free update
                                // point while scanning.
                                if (pend_flag) begin
                                    shadow    <= pend;
                                    pend_flag <= 1'b0;
                                end
                            end else begin
                                idx <= idx + IW'(1);
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end

                    default: begin
                        state   <= ST_OFF;
                        idx     <= '0;
                        cnt     <= '0;
                        seg_out <= SEG_OFF;
                        an_out  <= '1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sseg_scan_ctrl
//
// Bench for sseg_scan_ctrl with DIGITS=4, PRESCALE=4, BLANK_CYCLES=2. The
// board's decoder is modelled by hex7(). A position-in-frame model predicts
// every registered output per clock; directed vectors with literal values
// pin the model at the interesting points of each scenario.
// -----------------------------------------------------------------------------
module tb_sseg_scan_ctrl;

  localparam int D     = 4;
  localparam int PRE   = 4;
  localparam int BLK   = 2;
  localparam int SLOT  = PRE + BLK;
  localparam int FRAME = D * SLOT;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic rst;
  logic en;
  logic load_valid;
  logic [4*D-1:0] load_data;
  logic load_ready;
  logic [3:0] hex_out;
  logic [6:0] sseg_in;
  logic [6:0] seg_out;
  logic [D-1:0] an_out;

  int cyc;
  int t0;
  int total;
  int bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  sseg_scan_ctrl #(
    .DIGITS      (D),
    .PRESCALE    (PRE),
    .BLANK_CYCLES(BLK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .hex_out   (hex_out),
    .sseg_in   (sseg_in),
    .seg_out   (seg_out),
    .an_out    (an_out)
  );

  // Board decoder, active low, bit order gfedcba.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  assign sseg_in = hex7(hex_out);

  // ---------------------------------------------------------------- checking
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] nib(input logic [4*D-1:0] v, input int d);
    return v[d*4 +: 4];
  endfunction

  // What digit d shows for a given shadow value.
  function automatic logic [6:0] digit_seg(input logic [4*D-1:0] v, input int d);
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && ((v >> (4 * d)) == '0)) return 7'h7F;
`endif
    return hex7(nib(v, d));
  endfunction

  // ---------------------------------------------------------------- model
  // Scanning is described by m_k, the number of cycles since the scan left
  // OFF: position m_k within a SLOT tells blank vs drive, m_k / SLOT the digit.
  logic [15:0] exp_q[$];
  bit          m_on;
  int          m_k;
  logic [4*D-1:0] m_shadow;
  logic [4*D-1:0] m_pend;
  bit          m_pflag;
  bit          m_cap;
  bit          m_com;
  int          m_pos;
  int          m_dig;
  logic [D-1:0] e_an;
  logic [6:0]  e_seg;
  logic [3:0]  e_hex;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_on     = 1'b0;
      m_k      = 0;
      m_shadow = '0;
      m_pend   = '0;
      m_pflag  = 1'b0;
      exp_q.delete();
    end else begin
      e_an  = '1;
      e_seg = 7'h7F;
      if (en && m_on) begin
        m_pos = m_k % SLOT;
        m_dig = (m_k / SLOT) % D;
        if (m_pos >= BLK) begin
          e_an  = ~(D'(1) << m_dig);
          e_seg = digit_seg(m_shadow, m_dig);
        end
      end
      m_com = m_pflag && (!m_on || (en && ((m_k + 1) % FRAME == 0)));
      m_cap = load_valid && !m_pflag;
      if (m_com) begin
        m_shadow = m_pend;
        m_pflag  = 1'b0;
      end
      if (m_cap) begin
        m_pend  = load_data;
        m_pflag = 1'b1;
      end
      if (!en) begin
        m_on = 1'b0;
      end else if (!m_on) begin
        m_on = 1'b1;
        m_k  = 0;
      end else begin
        m_k = m_k + 1;
      end
      e_hex = nib(m_shadow, m_on ? (m_k / SLOT) % D : 0);
      exp_q.push_back({e_an, e_seg, !m_pflag, e_hex});
    end
  end

  // One compare per clock, 1 time unit after the active edge.
  always @(posedge clk) begin
    logic [15:0] e;
    #1;
    if (rst) begin
      chk("rst_an", 32'(an_out), 32'hF);
      chk("rst_seg", 32'(seg_out), 32'h7F);
      chk("rst_ready", 32'(load_ready), 32'h1);
      chk("rst_hex", 32'(hex_out), 32'h0);
    end else if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL model_empty: got no expectation at t=%0t", $time);
    end else begin
      e = exp_q.pop_front();
      chk("an_out", 32'(an_out), 32'(e[15:12]));
      chk("seg_out", 32'(seg_out), 32'(e[11:5]));
      chk("load_ready", 32'(load_ready), 32'(e[4]));
      chk("hex_out", 32'(hex_out), 32'(e[3:0]));
    end
  end

  // ---------------------------------------------------------------- driver tasks
  // Advance to the negedge following relative posedge n.
  task automatic step_to(input int n);
    int guard;
    guard = 0;
    while (cyc != t0 + n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) begin
      total++;
      bad++;
      $display("FAIL step_to: got cycle %0d expected %0d", cyc, t0 + n);
    end
  endtask

  task automatic drive_load(input logic v, input logic [4*D-1:0] d);
    load_valid = v;
    load_data  = d;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    t0    = 0;
    rst   = 1'b1;
    en    = 1'b0;
    drive_load(1'b0, '0);
    repeat (2) @(negedge clk);
    chk("init_an", 32'(an_out), 32'hF);
    chk("init_seg", 32'(seg_out), 32'h7F);
    chk("init_ready", 32'(load_ready), 32'h1);
    chk("init_hex", 32'(hex_out), 32'h0);
    rst = 1'b0;
    t0  = cyc + 1;

    // Load while OFF, then start scanning.
    step_to(0);  drive_load(1'b1, 16'h1234);
    step_to(1);  drive_load(1'b0, '0);
                 chk("off_ready_low", 32'(load_ready), 32'h0);
    step_to(2);  en = 1'b1;
                 chk("off_commit_ready", 32'(load_ready), 32'h1);
                 chk("off_commit_hex", 32'(hex_out), 32'h4);
    step_to(6);  chk("d0_an", 32'(an_out), 32'hE);
                 chk("d0_seg", 32'(seg_out), 32'h19);
    step_to(10); chk("gap_an", 32'(an_out), 32'hF);
                 chk("gap_seg", 32'(seg_out), 32'h7F);
    step_to(12); chk("d1_an", 32'(an_out), 32'hD);
                 chk("d1_seg", 32'(seg_out), 32'h30);
                 drive_load(1'b1, 16'hABCD);

    // Mid-frame load is held off until the frame ends.
    step_to(13); drive_load(1'b0, '0);
                 chk("mid_ready_low", 32'(load_ready), 32'h0);
    step_to(14); drive_load(1'b1, 16'hEEEE);
    step_to(16); drive_load(1'b0, '0);
    step_to(18); chk("d2_old_an", 32'(an_out), 32'hB);
                 chk("d2_old_seg", 32'(seg_out), 32'h24);
    step_to(20); drive_load(1'b1, 16'h5555);
    step_to(24); chk("d3_old_an", 32'(an_out), 32'h7);
                 chk("d3_old_seg", 32'(seg_out), 32'h79);
    step_to(26); chk("pre_commit_ready", 32'(load_ready), 32'h0);
    step_to(27); chk("commit_ready", 32'(load_ready), 32'h1);
    step_to(28); chk("accept_first_ready", 32'(load_ready), 32'h0);
                 drive_load(1'b0, '0);
    step_to(30); chk("f1_d0_seg", 32'(seg_out), 32'h21);
                 chk("f1_d0_an", 32'(an_out), 32'hE);

    // Enable drop during digit 2 of the 16'h5555 frame.
    step_to(66); chk("f2_d2_seg", 32'(seg_out), 32'h12);
                 en = 1'b0;
    step_to(67); chk("drop_an", 32'(an_out), 32'hF);
                 chk("drop_seg", 32'(seg_out), 32'h7F);
    step_to(68); drive_load(1'b1, 16'h0070);
    step_to(69); drive_load(1'b0, '0);
    step_to(71); en = 1'b1;
    step_to(73); chk("restart_blank", 32'(an_out), 32'hF);
    step_to(75); chk("lz_d0_an", 32'(an_out), 32'hE);
                 chk("lz_d0_seg", 32'(seg_out), 32'h40);
    step_to(81); chk("lz_d1_seg", 32'(seg_out), 32'h78);
    step_to(87); chk("lz_d2_an", 32'(an_out), 32'hB);
`ifdef LEADING_ZERO_BLANK_EN
                 chk("lz_d2_seg", 32'(seg_out), 32'h7F);
`else
                 chk("lz_d2_seg", 32'(seg_out), 32'h40);
`endif
    step_to(90); drive_load(1'b1, 16'h9999);
    step_to(91); drive_load(1'b0, '0);
    step_to(93); chk("lz_d3_an", 32'(an_out), 32'h7);
`ifdef LEADING_ZERO_BLANK_EN
                 chk("lz_d3_seg", 32'(seg_out), 32'h7F);
`else
                 chk("lz_d3_seg", 32'(seg_out), 32'h40);
`endif

    // Reset mid-DRIVE with a value pending: pending is discarded.
    step_to(94); rst = 1'b1;
                 en  = 1'b0;
                 #1;
                 chk("midrst_an", 32'(an_out), 32'hF);
                 chk("midrst_seg", 32'(seg_out), 32'h7F);
                 chk("midrst_ready", 32'(load_ready), 32'h1);
                 chk("midrst_hex", 32'(hex_out), 32'h0);
    step_to(96); rst = 1'b0;
    step_to(100); chk("post_rst_an", 32'(an_out), 32'hF);
                  chk("post_rst_hex", 32'(hex_out), 32'h0);
                  chk("post_rst_ready", 32'(load_ready), 32'h1);
    step_to(103);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
Time-multiplexing scan controller for a multi-digit common-anode seven-segment display. A single shared hex-to-seven-segment decoder serves all digits.
- The block accepts a packed hex value through a valid/ready handshake and holds it in a shadow register.
- It presents one nibble at a time to the shared decoder and registers the decoder's active-low segment pattern.
- It drives the active-low digit anodes, with a blanking gap between digits to prevent ghosting.
- It sits between the display-value producer and the board's segment and anode pins.

Parameters:
DIGITS, 4, number of digits scanned (1..8).
PRESCALE, 50000, clk cycles each digit is driven (>=2).
BLANK_CYCLES, 500, clk cycles with all anodes off between digits (>=1).

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  scan enable; low forces display off.
load_valid  input  1  producer offers load_data.
load_data  input  4*DIGITS  packed hex value; nibble i is digit i, where digit 0 is the least-significant nibble.
load_ready  output  1  block can accept a value.
hex_out  output  4  nibble presented to the shared decoder.
sseg_in  input  7  active-low segment pattern returned by the decoder (combinational from hex_out).
seg_out  output  7  registered active-low segments to the pins.
an_out  output  DIGITS  registered active-low anode enables; bit i is digit i.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values:
  - Internal: state OFF, digit index 0, shadow 0, pending register 0, pending flag 0, counter 0.
  - Outputs: seg_out = 7'h7F, an_out = all 1s, load_ready = 1, hex_out = 0.
- Handshake:
  - load_ready = !pending_flag.
  - A transfer occurs when load_valid && load_ready. load_data is captured into the pending register and pending_flag sets.
  - load_valid with load_ready low is ignored. The producer must hold it.
- Commit (pending -> shadow, pending_flag cleared) happens only at a frame boundary, so a frame never tears:
  - on the DRIVE->BLANK transition of digit DIGITS-1; or
  - on any cycle in OFF while pending_flag = 1.
- Capture on the same cycle as a commit point is impossible, because ready implies the pending register is empty. The captured value commits at the next boundary.
- hex_out = shadow nibble[digit index], combinational from registers.
- FSM (counter counts cycles spent in the current state):
  - OFF:
    - an_out = all 1s, seg_out = 7'h7F.
    - en = 1 -> BLANK with digit index 0 and counter 0.
  - BLANK:
    - an_out = all 1s, seg_out = 7'h7F. The decoder settles on the new hex_out.
    - After BLANK_CYCLES cycles -> DRIVE with counter 0.
  - DRIVE:
    - Each cycle, an_out <= ~(1 << digit index) and seg_out <= sseg_in. Outputs therefore lag the state by 1 cycle.
    - After PRESCALE cycles -> BLANK. The digit index increments on this edge and wraps DIGITS-1 -> 0.
  - Any state with en = 0:
    - The next edge goes to OFF. an_out and seg_out are blank on that same edge, and the digit index resets to 0.
- Frame length: DIGITS*(PRESCALE+BLANK_CYCLES) cycles.
- The counter is wide enough for max(PRESCALE, BLANK_CYCLES).
- Reset mid-scan: everything returns to reset values immediately. A pending value is discarded.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: in DRIVE, digit i>0 shows seg_out = 7'h7F if shadow nibbles i..DIGITS-1 are all zero. Its anode still asserts. Digit 0 always displays.
- Not defined: every digit displays its nibble, including leading zeros.

Test Plan:
All scenarios use DIGITS=4, PRESCALE=4, BLANK_CYCLES=2 (frame = 24 cycles).
1. Reset: assert rst mid-DRIVE -> same cycle seg_out=7'h7F, an_out=4'hF, load_ready=1. After release with en=0, outputs stay blank.
2. Load while OFF: load 16'h1234, then en=1 -> 2 blank cycles, then an_out=4'b1110 with seg_out=sseg_in for hex_out=4. Next an_out=4'b1101 for 3, then 2, then 1. Anodes are all high for exactly 2 cycles between digits.
3. Tear-free update: load 16'hABCD mid-frame while 16'h1234 displays -> load_ready=0 until the digit-3 DRIVE->BLANK edge. Digits 2 and 3 of the current frame still show 2 and 1. The next frame shows D,C,B,A.
4. Back-pressure: after a held-off load, offer 16'h5555 with load_ready=0 -> not captured. It is accepted on the first cycle ready=1, and the ignored value is never displayed.
5. Enable drop: en=0 during digit 2 DRIVE -> next edge an_out=4'hF, seg_out=7'h7F. Re-enable restarts at digit 0 after 2 blank cycles.
6. LEADING_ZERO_BLANK_EN: shadow 16'h0070 -> digits 3 and 2 have seg_out=7'h7F, digit 1 shows 7, digit 0 shows 0. Without the macro, all four digits show their nibbles.
